ras_stack: RTL and testbench

- Parametrised return-address stack for the fetch-stage branch predictor.
- Circular LIFO of configurable width and depth with:
  - selectable overflow mode (wrap-and-overwrite or drop);
  - single-cycle push+pop replace, for tail calls;
  - one-level checkpoint/restore, used to repair the stack after a branch mispredict flush.
- Pushed on call, popped on return; peek supplies the predicted return target combinationally.

---
 rtl/ras_stack.sv | 133 +++++++++++++
 tb/tb_ras_stack.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack with overflow mode, replace and one-level checkpoint
module ras_stack #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter bit OVERWRITE = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           datain,
  input  logic                       checkpoint,
  input  logic                       restore,
  output logic [WIDTH-1:0]           peek,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    snap_ptr_q, snap_ptr_d;
  logic [CW-1:0]    snap_cnt_q, snap_cnt_d;
  logic [WIDTH-1:0] snap_top_q, snap_top_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    top_idx;
  logic             is_empty;
  logic             is_full;

  assign top_idx  = ptr_q - AW'(1);
  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == DEPTH_C);

  assign peek      = is_empty ? '0 : mem_q[top_idx];
  assign empty     = is_empty;
  assign full      = is_full;
  assign count     = cnt_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_comb begin
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    snap_ptr_d  = snap_ptr_q;
    snap_cnt_d  = snap_cnt_q;
    snap_top_d  = snap_top_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = ptr_q;
    wr_data     = datain;

    if (restore) begin
      // Rewriting the saved top repairs a slot clobbered by a later replace or push.
      ptr_d = snap_ptr_q;
      cnt_d = snap_cnt_q;
      if (snap_cnt_q != '0) begin
        wr_en   = 1'b1;
        wr_addr = snap_ptr_q - AW'(1);
        wr_data = snap_top_q;
      end
    end else begin
      if (checkpoint) begin
        snap_ptr_d = ptr_q;
        snap_cnt_d = cnt_q;
        snap_top_d = peek;
      end

      if (push && pop && !is_empty) begin
        wr_en   = 1'b1;
        wr_addr = top_idx;
      end else if (push) begin
        if (!is_full) begin
          wr_en = 1'b1;
          ptr_d = ptr_q + AW'(1);
          cnt_d = cnt_q + CW'(1);
        end else begin
          overflow_d = 1'b1;
          if (OVERWRITE) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + AW'(1);
          end
        end
      end else if (pop) begin
        if (!is_empty) begin
          ptr_d = top_idx;
          cnt_d = cnt_q - CW'(1);
        end else begin
          underflow_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      cnt_q       <= '0;
      snap_ptr_q  <= '0;
      snap_cnt_q  <= '0;
      snap_top_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      snap_ptr_q  <= snap_ptr_d;
      snap_cnt_q  <= snap_cnt_d;
      snap_top_q  <= snap_top_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      if (wr_en) begin
        mem_q[wr_addr] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_ras_stack.sv
// tb/tb_ras_stack.sv - scoreboard bench for ras_stack in overwrite and drop overflow modes
module tb_ras_stack;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [31:0] datain = '0;
  logic        checkpoint = 1'b0;
  logic        restore = 1'b0;

  logic [31:0] peek_w, peek_d;
  logic        empty_w, empty_d, full_w, full_d;
  logic [4:0]  count_w, count_d;
  logic        ovf_w, ovf_d, unf_w, unf_d;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    string       name;
    bit          sel;
    logic [31:0] pk;
    logic [4:0]  cnt;
    logic        emp;
    logic        ful;
    logic        ov;
    logic        un;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  ras_stack #(.WIDTH(32), .DEPTH(16), .OVERWRITE(1'b1)) dut_w (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .datain(datain),
    .checkpoint(checkpoint), .restore(restore), .peek(peek_w), .empty(empty_w),
    .full(full_w), .count(count_w), .overflow(ovf_w), .underflow(unf_w)
  );

  ras_stack #(.WIDTH(32), .DEPTH(16), .OVERWRITE(1'b0)) dut_d (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .datain(datain),
    .checkpoint(checkpoint), .restore(restore), .peek(peek_d), .empty(empty_d),
    .full(full_d), .count(count_d), .overflow(ovf_d), .underflow(unf_d)
  );

  task automatic chk(input string name, input string fld, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", name, fld, act, req);
    end
  endtask

  // Monitor: outputs are stable at the falling edge; compare everything queued since the last edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.sel == 1'b0) begin
          chk(e.name, "peek", peek_w, e.pk);
          chk(e.name, "count", 32'(count_w), 32'(e.cnt));
          chk(e.name, "empty", 32'(empty_w), 32'(e.emp));
          chk(e.name, "full", 32'(full_w), 32'(e.ful));
          chk(e.name, "overflow", 32'(ovf_w), 32'(e.ov));
          chk(e.name, "underflow", 32'(unf_w), 32'(e.un));
        end else begin
          chk(e.name, "peek", peek_d, e.pk);
          chk(e.name, "count", 32'(count_d), 32'(e.cnt));
          chk(e.name, "empty", 32'(empty_d), 32'(e.emp));
          chk(e.name, "full", 32'(full_d), 32'(e.ful));
          chk(e.name, "overflow", 32'(ovf_d), 32'(e.ov));
          chk(e.name, "underflow", 32'(unf_d), 32'(e.un));
        end
      end
    end
  end

  task automatic drive(input logic r, input logic pu, input logic po, input logic [31:0] d,
                       input logic ck, input logic rs);
    rst = r; push = pu; pop = po; datain = d; checkpoint = ck; restore = rs;
    @(posedge clk);
    #1;
    rst = 1'b0; push = 1'b0; pop = 1'b0; datain = '0; checkpoint = 1'b0; restore = 1'b0;
  endtask

  task automatic do_rst();             drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0); endtask
  task automatic do_push(input logic [31:0] d); drive(1'b0, 1'b1, 1'b0, d, 1'b0, 1'b0); endtask
  task automatic do_pop();             drive(1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0); endtask
  task automatic do_pp(input logic [31:0] d);   drive(1'b0, 1'b1, 1'b1, d, 1'b0, 1'b0); endtask
  task automatic do_ck();              drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0); endtask
  task automatic do_rs();              drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1); endtask
  task automatic do_idle();            drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0); endtask

  task automatic expect_out(input string name, input bit sel, input logic [31:0] pk, input int cnt,
                            input logic ov, input logic un);
    exp_t e;
    e.name = name; e.sel = sel; e.pk = pk; e.cnt = 5'(cnt);
    e.emp = (cnt == 0); e.ful = (cnt == 16); e.ov = ov; e.un = un;
    sb.push_back(e);
  endtask

  initial begin
    int budget;

    do_rst();
    expect_out("reset_w", 1'b0, 32'h0, 0, 1'b0, 1'b0);
    expect_out("reset_d", 1'b1, 32'h0, 0, 1'b0, 1'b0);

    // Basic LIFO and underflow
    do_push(32'h100); do_push(32'h200); do_push(32'h300);
    expect_out("t1_push3", 1'b0, 32'h300, 3, 1'b0, 1'b0);
    do_pop();  expect_out("t1_pop1", 1'b0, 32'h200, 2, 1'b0, 1'b0);
    do_pop();  expect_out("t1_pop2", 1'b0, 32'h100, 1, 1'b0, 1'b0);
    do_pop();  expect_out("t1_pop3", 1'b0, 32'h0, 0, 1'b0, 1'b0);
    do_pop();  expect_out("t1_underflow", 1'b0, 32'h0, 0, 1'b0, 1'b1);
    do_idle(); expect_out("t1_unf_clear", 1'b0, 32'h0, 0, 1'b0, 1'b0);

    // Overwrite-mode wrap
    do_rst();
    for (int i = 1; i <= 16; i++) do_push(32'(i));
    expect_out("t2_full", 1'b0, 32'h10, 16, 1'b0, 1'b0);
    do_push(32'h11);
    expect_out("t2_overflow", 1'b0, 32'h11, 16, 1'b1, 1'b0);
    do_idle(); expect_out("t2_ovf_clear", 1'b0, 32'h11, 16, 1'b0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      do_pop();
      expect_out($sformatf("t2_pop%0d", k), 1'b0, (k < 16) ? 32'(17 - k) : 32'h0, 16 - k, 1'b0, 1'b0);
    end

    // Drop mode versus overwrite mode on the same overflowing push
    do_rst();
    for (int i = 1; i <= 16; i++) do_push(32'(i));
    do_push(32'hAA);
    expect_out("t3_drop", 1'b1, 32'h10, 16, 1'b1, 1'b0);
    expect_out("t3_wrap", 1'b0, 32'hAA, 16, 1'b1, 1'b0);

    // Replace-top
    do_rst();
    do_push(32'h40); do_push(32'h50);
    do_pp(32'h60); expect_out("t4_replace", 1'b0, 32'h60, 2, 1'b0, 1'b0);
    do_pop();      expect_out("t4_pop", 1'b0, 32'h40, 1, 1'b0, 1'b0);
    do_pop();      expect_out("t4_empty", 1'b0, 32'h0, 0, 1'b0, 1'b0);
    do_pp(32'h70); expect_out("t4_pp_empty", 1'b0, 32'h70, 1, 1'b0, 1'b0);

    // Checkpoint / restore; entry below the top replaced after the checkpoint stays replaced
    do_rst();
    do_push(32'h10); do_push(32'h20);
    do_ck();       expect_out("t5_ckpt", 1'b0, 32'h20, 2, 1'b0, 1'b0);
    do_pop();      expect_out("t5_pop", 1'b0, 32'h10, 1, 1'b0, 1'b0);
    do_pp(32'h99); expect_out("t5_replace", 1'b0, 32'h99, 1, 1'b0, 1'b0);
    do_push(32'h33); expect_out("t5_push", 1'b0, 32'h33, 2, 1'b0, 1'b0);
    do_rs();       expect_out("t5_restore", 1'b0, 32'h20, 2, 1'b0, 1'b0);
    do_pop();      expect_out("t5_pop_after", 1'b0, 32'h99, 1, 1'b0, 1'b0);
    do_rs();       expect_out("t5_restore2", 1'b0, 32'h20, 2, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 32'h77, 1'b1, 1'b1);
    expect_out("t5_restore_wins", 1'b0, 32'h20, 2, 1'b0, 1'b0);

    // Reset overrides everything and clears the snapshot
    do_rst();
    do_push(32'h1); do_push(32'h2); do_push(32'h3);
    do_ck();
    do_push(32'h4); do_push(32'h5);
    expect_out("t6_pre", 1'b0, 32'h5, 5, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 32'hDEAD, 1'b1, 1'b1);
    expect_out("t6_rst_all", 1'b0, 32'h0, 0, 1'b0, 1'b0);
    do_rs();
    expect_out("t6_restore_after_rst", 1'b0, 32'h0, 0, 1'b0, 1'b0);
    do_pop();
    expect_out("t6_unf_after_rst", 1'b1, 32'h0, 0, 1'b0, 1'b1);

    budget = 0;
    while (sb.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    if (sb.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
